mmu_tile_sequencer: RTL and testbench

MMU_TILE_SEQUENCER -- requirements
Module: mmu_tile_sequencer

---
 rtl/mmu_tile_sequencer.sv | 127 ++++++++++++
 tb/tb_mmu_tile_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_tile_sequencer.sv
// Sequences K-tile operand fetches into a fixed-latency MMU pipeline and steers
// the accumulator, then posts a completion record for each command.
module mmu_tile_sequencer #(
  parameter int TILE_CNT_W = 8,
  parameter int PIPE_LAT   = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [TILE_CNT_W-1:0] cmd_tiles_i,
  input  logic [3:0]            cmd_id_i,
  input  logic                  abort_i,
  output logic                  fetch_req_o,
  output logic [TILE_CNT_W-1:0] fetch_idx_o,
  input  logic                  fetch_gnt_i,
  output logic                  mmu_enable_o,
  output logic                  acc_en_o,
  output logic                  acc_first_o,
  output logic                  done_valid_o,
  input  logic                  done_ready_i,
  output logic [3:0]            done_id_o,
  output logic                  done_err_o,
  output logic                  busy_o,
  output logic [31:0]           stall_cnt_o
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [TILE_CNT_W-1:0] tiles_q, tiles_d;
  logic [3:0]            id_q, id_d;
  logic                  err_q, err_d;
  logic [TILE_CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [TILE_CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [PIPE_LAT-1:0]   tag_q, tag_d;
  logic [31:0]           stall_q, stall_d;

  logic [TILE_CNT_W-1:0] issue_next;
  logic [TILE_CNT_W-1:0] res_next;

  assign issue_next = issue_cnt_q + 1'b1;
  assign res_next   = res_cnt_q + 1'b1;

  // Every output decodes registered state only, so nothing glitches combinationally.
  assign cmd_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign fetch_req_o  = (state_q == FETCH);
  assign fetch_idx_o  = (state_q == FETCH) ? issue_cnt_q : '0;
  assign mmu_enable_o = (state_q == ISSUE) || (state_q == DRAIN);
  assign acc_en_o     = mmu_enable_o && tag_q[PIPE_LAT-1];
  assign acc_first_o  = acc_en_o && (res_cnt_q == '0);
  assign done_valid_o = (state_q == DONE);
  assign done_id_o    = (state_q == DONE) ? id_q : '0;
  assign done_err_o   = (state_q == DONE) ? err_q : 1'b0;
  assign stall_cnt_o  = stall_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d     = state_q;
    tiles_d     = tiles_q;
    id_d        = id_q;
    err_d       = err_q;
    issue_cnt_d = issue_cnt_q;
    res_cnt_d   = res_cnt_q;
    tag_d       = tag_q;
    stall_d     = stall_q;

    // The tag register mirrors the MMU pipeline: it moves only when the MMU advances.
    if (mmu_enable_o) tag_d = {tag_q[PIPE_LAT-2:0], (state_q == ISSUE)};
    if (acc_en_o)     res_cnt_d = res_next;
    if ((state_q == FETCH) && !fetch_gnt_i && (stall_q != '1)) stall_d = stall_q + 32'd1;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          tiles_d     = cmd_tiles_i;
          id_d        = cmd_id_i;
          err_d       = (cmd_tiles_i == '0);
          issue_cnt_d = '0;
          res_cnt_d   = '0;
          tag_d       = '0;
          state_d     = (cmd_tiles_i == '0) ? DONE : FETCH;
        end
      end
      FETCH: if (fetch_gnt_i) state_d = ISSUE;
      ISSUE: begin
        issue_cnt_d = issue_next;
        state_d     = (issue_next == tiles_q) ? DRAIN : FETCH;
      end
      DRAIN: if (acc_en_o && (res_next == tiles_q)) state_d = DONE;
      DONE:  if (done_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_i && (state_q != IDLE)) begin
      state_d     = IDLE;
      issue_cnt_d = '0;
      res_cnt_d   = '0;
      tag_d       = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      tiles_q     <= '0;
      id_q        <= '0;
      err_q       <= 1'b0;
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
      tag_q       <= '0;
      stall_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q     <= state_d;
      tiles_q     <= tiles_d;
      id_q        <= id_d;
      err_q       <= err_d;
      issue_cnt_q <= issue_cnt_d;
      res_cnt_q   <= res_cnt_d;
      tag_q       <= tag_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_mmu_tile_sequencer.sv
// Directed bench for mmu_tile_sequencer: each task drives one scenario and
// compares outputs against hand-derived expectations.
module tb_mmu_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_tiles = '0;
  logic [3:0]  cmd_id = '0;
  logic        abort = 1'b0;
  logic        fetch_req;
  logic [7:0]  fetch_idx;
  logic        fetch_gnt = 1'b0;
  logic        mmu_en;
  logic        acc_en;
  logic        acc_first;
  logic        done_valid;
  logic        done_ready = 1'b0;
  logic [3:0]  done_id;
  logic        done_err;
  logic        busy;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mmu_tile_sequencer #(.TILE_CNT_W(8), .PIPE_LAT(6)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_tiles_i  (cmd_tiles),
    .cmd_id_i     (cmd_id),
    .abort_i      (abort),
    .fetch_req_o  (fetch_req),
    .fetch_idx_o  (fetch_idx),
    .fetch_gnt_i  (fetch_gnt),
    .mmu_enable_o (mmu_en),
    .acc_en_o     (acc_en),
    .acc_first_o  (acc_first),
    .done_valid_o (done_valid),
    .done_ready_i (done_ready),
    .done_id_o    (done_id),
    .done_err_o   (done_err),
    .busy_o       (busy),
    .stall_cnt_o  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Snapshot of every output; in reset only cmd_ready (the MSB) is high.
  logic [51:0] obs;
  assign obs = {cmd_ready, busy, fetch_req, fetch_idx, mmu_en, acc_en, acc_first,
                done_valid, done_id, done_err, stall_cnt};
  localparam logic [51:0] RESET_OBS = {1'b1, 51'd0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; abort = 1'b0; fetch_gnt = 1'b0; done_ready = 1'b0;
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if (obs !== RESET_OBS) begin
      n_fail++; $display("FAIL reset_outputs got %h exp %h", obs, RESET_OBS);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (obs !== RESET_OBS) begin
      n_fail++; $display("FAIL post_reset_idle got %h exp %h", obs, RESET_OBS);
    end
  endtask

  // One-tile command with immediate grant; ISSUE at t, result at t+6, DONE at t+7.
  task automatic run_single(input logic [3:0] id, input string tag);
    logic exp;
    cmd_valid = 1'b1; cmd_tiles = 8'd1; cmd_id = id; fetch_gnt = 1'b1;
    step();
    cmd_valid = 1'b0;
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_idx !== 8'd0) begin
      n_fail++; $display("FAIL %s_fetch got req=%b idx=%0d exp req=1 idx=0", tag, fetch_req, fetch_idx);
    end
    step();
    fetch_gnt = 1'b0;
    n_checks++;
    if (mmu_en !== 1'b1 || acc_en !== 1'b0) begin
      n_fail++; $display("FAIL %s_issue got mmu=%b acc=%b exp mmu=1 acc=0", tag, mmu_en, acc_en);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      exp = (k == 6);
      n_checks++;
      if (mmu_en !== 1'b1 || acc_en !== exp || acc_first !== exp) begin
        n_fail++;
        $display("FAIL %s_drain t+%0d got mmu=%b acc=%b first=%b exp mmu=1 acc=%b first=%b",
                 tag, k, mmu_en, acc_en, acc_first, exp, exp);
      end
    end
    step();
    n_checks++;
    if (done_valid !== 1'b1 || done_id !== id || done_err !== 1'b0 || mmu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done t+7 got v=%b id=%0d err=%b mmu=%b exp v=1 id=%0d err=0 mmu=0",
               tag, done_valid, done_id, done_err, mmu_en, id);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b1 || done_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_idle got rdy=%b v=%b exp rdy=1 v=0", tag, cmd_ready, done_valid);
    end
  endtask

  task automatic test_single();
    run_single(4'd5, "single");
  endtask

  task automatic test_multi_stall();
    logic [7:0] idx_seen[$];
    int stalls_left = 4;
    int n_acc = 0;
    int n_first = 0;
    bit first_ok = 1'b1;
    bit done_seen = 1'b0;
    do_reset();
    cmd_valid = 1'b1; cmd_tiles = 8'd3; cmd_id = 4'd3;
    step();
    cmd_valid = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (done_valid) begin done_seen = 1'b1; break; end
      if (acc_en) begin
        if (acc_first !== (n_acc == 0)) first_ok = 1'b0;
        if (acc_first) n_first++;
        n_acc++;
      end else if (acc_first) first_ok = 1'b0;
      if (fetch_req) begin
        if (stalls_left > 0) begin fetch_gnt = 1'b0; stalls_left--; end
        else begin fetch_gnt = 1'b1; idx_seen.push_back(fetch_idx); end
      end else fetch_gnt = 1'b0;
      step();
    end
    fetch_gnt = 1'b0;
    n_checks++;
    if (!done_seen || done_id !== 4'd3 || done_err !== 1'b0) begin
      n_fail++; $display("FAIL multi_done got seen=%b id=%0d err=%b exp seen=1 id=3 err=0", done_seen, done_id, done_err);
    end
    n_checks++;
    if (idx_seen.size() != 3) begin
      n_fail++; $display("FAIL multi_fetch_count got %0d exp 3", idx_seen.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (idx_seen[i] !== 8'(i)) begin
          n_fail++; $display("FAIL multi_fetch_idx[%0d] got %0d exp %0d", i, idx_seen[i], i);
        end
      end
    end
    n_checks++;
    if (n_acc != 3 || n_first != 1 || !first_ok) begin
      n_fail++; $display("FAIL multi_acc got pulses=%0d firsts=%0d order_ok=%b exp 3 1 1", n_acc, n_first, first_ok);
    end
    n_checks++;
    if (stall_cnt !== 32'd4) begin
      n_fail++; $display("FAIL multi_stall got %0d exp 4", stall_cnt);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
  endtask

  task automatic test_zero_tiles();
    cmd_valid = 1'b1; cmd_tiles = 8'd0; cmd_id = 4'd9;
    step();
    cmd_valid = 1'b0;
    n_checks++;
    if (done_valid !== 1'b1 || done_err !== 1'b1 || done_id !== 4'd9 || fetch_req !== 1'b0 || mmu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done got v=%b err=%b id=%0d req=%b mmu=%b exp v=1 err=1 id=9 req=0 mmu=0",
               done_valid, done_err, done_id, fetch_req, mmu_en);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b1 || done_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_idle got rdy=%b v=%b exp rdy=1 v=0", cmd_ready, done_valid);
    end
  endtask

  task automatic test_done_hold();
    bit reached = 1'b0;
    bit held_ok = 1'b1;
    cmd_valid = 1'b1; cmd_tiles = 8'd1; cmd_id = 4'd12;
    step();
    cmd_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done_valid) begin reached = 1'b1; break; end
      fetch_gnt = fetch_req;
      step();
    end
    fetch_gnt = 1'b0;
    n_checks++;
    if (!reached) begin
      n_fail++; $display("FAIL hold_reach got done_valid=0 exp 1 within 30 cycles");
    end
    for (int c = 0; c < 10; c++) begin
      if (done_valid !== 1'b1 || done_id !== 4'd12 || done_err !== 1'b0 || cmd_ready !== 1'b0) held_ok = 1'b0;
      step();
    end
    n_checks++;
    if (!held_ok || done_valid !== 1'b1) begin
      n_fail++; $display("FAIL hold_stable got v=%b id=%0d rdy=%b exp v=1 id=12 rdy=0", done_valid, done_id, cmd_ready);
    end
    // A command offered alongside done_ready must wait one cycle in IDLE.
    done_ready = 1'b1; cmd_valid = 1'b1; cmd_tiles = 8'd0; cmd_id = 4'd1;
    step();
    done_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || done_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release got busy=%b rdy=%b v=%b exp 0 1 0", busy, cmd_ready, done_valid);
    end
    step();
    cmd_valid = 1'b0;
    n_checks++;
    if (done_valid !== 1'b1 || done_id !== 4'd1) begin
      n_fail++; $display("FAIL hold_next_cmd got v=%b id=%0d exp v=1 id=1", done_valid, done_id);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
  endtask

  task automatic test_abort();
    int n_acc = 0;
    bit no_done = 1'b1;
    cmd_valid = 1'b1; cmd_tiles = 8'd4; cmd_id = 4'd7;
    step();
    cmd_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done_valid) no_done = 1'b0;
      if (acc_en) n_acc++;
      if (n_acc == 2) break;
      fetch_gnt = fetch_req;
      step();
    end
    fetch_gnt = 1'b0;
    n_checks++;
    if (n_acc != 2 || fetch_req !== 1'b0 || mmu_en !== 1'b1) begin
      n_fail++; $display("FAIL abort_setup got acc=%0d req=%b mmu=%b exp 2 0 1", n_acc, fetch_req, mmu_en);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || done_valid !== 1'b0 || mmu_en !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle got busy=%b rdy=%b v=%b mmu=%b exp 0 1 0 0", busy, cmd_ready, done_valid, mmu_en);
    end
    for (int c = 0; c < 3; c++) begin
      if (done_valid !== 1'b0) no_done = 1'b0;
      step();
    end
    n_checks++;
    if (!no_done) begin
      n_fail++; $display("FAIL abort_no_record got done_valid=1 exp 0");
    end
    run_single(4'd5, "after_abort");
  endtask

  task automatic test_reset_mid();
    do_reset();
    cmd_valid = 1'b1; cmd_tiles = 8'd2; cmd_id = 4'd6; fetch_gnt = 1'b0;
    step();
    cmd_valid = 1'b0;
    repeat (7) step();
    n_checks++;
    if (stall_cnt !== 32'd7 || fetch_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_setup got stall=%0d req=%b exp 7 1", stall_cnt, fetch_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== RESET_OBS) begin
      n_fail++; $display("FAIL rst_mid_async got %h exp %h", obs, RESET_OBS);
    end
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    n_checks++;
    if (obs !== RESET_OBS) begin
      n_fail++; $display("FAIL rst_mid_after got %h exp %h", obs, RESET_OBS);
    end
    run_single(4'd5, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_stall();
    test_zero_tiles();
    test_done_hold();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
